instr_stream_encoder: RTL and testbench

// - Encoder counterpart of the main controller's opcode decoder. Accepts symbolic instructions
//   (class + register/immediate fields) over a valid/ready handshake.
// - Packs each one into a 32-bit MIPS word and writes it to instruction memory at consecutive

---
 rtl/instr_stream_encoder_pkg.sv | 48 ++++
 rtl/instr_pack.sv | 36 +++
 rtl/instr_stream_encoder.sv | 152 +++++++++++++++
 tb/tb_instr_stream_encoder.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_stream_encoder_pkg.sv
// Shared instruction constants: the same opcode/funct values the core's controller decodes,
// the symbolic instruction classes accepted by the encoder, and word-packing helpers.
package instr_stream_encoder_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_JAL   = 6'b000011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_ADDI = 4'd5,
        OP_ANDI = 4'd6,
        OP_LW   = 4'd7,
        OP_SW   = 4'd8,
        OP_JAL  = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic instruction class plus fields -> 32-bit MIPS word.
// Codes outside the supported set yield a zero word and raise illegal.
module instr_pack
    import instr_stream_encoder_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the encoding for the instruction class
    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (op_e'(op))
            OP_ADD:  word = pack_r(rs, rt, rd, FUNCT_ADD);
            OP_SUB:  word = pack_r(rs, rt, rd, FUNCT_SUB);
            OP_AND:  word = pack_r(rs, rt, rd, FUNCT_AND);
            OP_OR:   word = pack_r(rs, rt, rd, FUNCT_OR);
            OP_SLT:  word = pack_r(rs, rt, rd, FUNCT_SLT);
            OP_ADDI: word = pack_i(OPC_ADDI, rs, rt, imm);
            OP_ANDI: word = pack_i(OPC_ANDI, rs, rt, imm);
            OP_LW:   word = pack_i(OPC_LW, rs, rt, imm);
            OP_SW:   word = pack_i(OPC_SW, rs, rt, imm);
            // The controller always links to $31, so register fields are dropped
            OP_JAL:  word = {OPC_JAL, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Streams symbolic instructions into instruction memory: accepts one instruction per two
// cycles, writes legal ones at consecutive word addresses, and flags illegal ops and overflow.
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_r;
    state_e            state_s;
    logic [31:0]       word_s;
    logic              illegal_s;
    logic              accept_s;
    logic              start_ok_s;
    logic [ADDR_W:0]   count_inc_s;
    logic              cap_hit_s;
    logic              last_r;
    logic              illegal_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              err_r;
    logic              ovf_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;

    instr_pack u_pack (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (word_s),
        .illegal (illegal_s)
    );

    assign accept_s    = (state_r == ST_LOAD) && in_valid;
    assign start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign count_inc_s = count_r + CNT_ONE;
    // A legal write filling the last free word is exactly the point where ptr wraps to base
    assign cap_hit_s   = (count_inc_s == CAPACITY);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_LOAD;
                else       state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (in_valid) state_s = ST_WRITE;
                else          state_s = ST_LOAD;
            end
            ST_WRITE: begin
                if (last_r || (!illegal_r && cap_hit_s)) state_s = ST_DONE;
                else                                     state_s = ST_LOAD;
            end
            ST_DONE: begin
                if (start) state_s = ST_LOAD;
                else       state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Capture on accept, commit pointer/count/flags in WRITE, re-initialise on start
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r    <= 1'b0;
            illegal_r <= 1'b0;
            ptr_r     <= {ADDR_W{1'b0}};
            count_r   <= {(ADDR_W+1){1'b0}};
            err_r     <= 1'b0;
            ovf_r     <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= 32'h0000_0000;
        end else begin
            we_r <= accept_s && !illegal_s;
            if (accept_s) begin
                addr_r    <= ptr_r;
                wdata_r   <= word_s;
                last_r    <= in_last;
                illegal_r <= illegal_s;
            end
            if (start_ok_s) begin
                ptr_r   <= base_addr;
                count_r <= {(ADDR_W+1){1'b0}};
                err_r   <= 1'b0;
                ovf_r   <= 1'b0;
            end else if (state_r == ST_WRITE) begin
                if (illegal_r) begin
                    err_r <= 1'b1;
                end else begin
                    ptr_r   <= ptr_r + PTR_ONE;
                    count_r <= count_inc_s;
                    if (cap_hit_s) ovf_r <= 1'b1;
                end
            end
        end
    end

    // Strobe is masked by rst so a reset during WRITE aborts the pending write
    assign mem_we    = we_r && !rst;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign in_ready  = (state_r == ST_LOAD);
    assign busy      = (state_r == ST_LOAD) || (state_r == ST_WRITE);
    assign done      = (state_r == ST_DONE);
    assign err       = err_r;
    assign ovf       = ovf_r;
    assign count     = count_r;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: an 8-bit-address instance for the main scenarios and a
// 2-bit-address instance for wrap/overflow; memory writes are checked against a scoreboard.
module tb_instr_stream_encoder;
    import instr_stream_encoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        start8 = 1'b0;
    logic        start2 = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic        in_valid = 1'b0;
    logic [3:0]  in_op = 4'd0;
    logic [4:0]  in_rs = 5'd0;
    logic [4:0]  in_rt = 5'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [15:0] in_imm = 16'd0;
    logic [25:0] in_target = 26'd0;
    logic        in_last = 1'b0;

    logic        rdy8, we8, busy8, done8, err8, ovf8;
    logic [7:0]  addr8;
    logic [31:0] wd8;
    logic [8:0]  cnt8;
    logic        rdy2, we2, busy2, done2, err2, ovf2;
    logic [1:0]  addr2;
    logic [31:0] wd2;
    logic [2:0]  cnt2;

    int          checks = 0;
    int          errors = 0;
    bit          use2 = 1'b0;
    logic [39:0] sb[$];
    logic [39:0] mon_exp;

    logic        rdy_sel, we_sel, done_sel;
    logic [7:0]  addr_sel;
    logic [31:0] wd_sel;

    assign rdy_sel  = use2 ? rdy2 : rdy8;
    assign we_sel   = use2 ? we2 : we8;
    assign done_sel = use2 ? done2 : done8;
    assign addr_sel = use2 ? {6'b000000, addr2} : addr8;
    assign wd_sel   = use2 ? wd2 : wd8;

    instr_stream_encoder #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(rdy8), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .mem_we(we8), .mem_addr(addr8), .mem_wdata(wd8), .busy(busy8), .done(done8),
        .err(err8), .ovf(ovf8), .count(cnt8)
    );

    instr_stream_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr[1:0]),
        .in_valid(in_valid), .in_ready(rdy2), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .mem_we(we2), .mem_addr(addr2), .mem_wdata(wd2), .busy(busy2), .done(done2),
        .err(err2), .ovf(ovf2), .count(cnt2)
    );

    // Write monitor: every strobe must match the oldest expected write
    always @(negedge clk) begin
        if (we_sel === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h, no write expected", addr_sel, wd_sel);
            end else begin
                mon_exp = sb.pop_front();
                if ({addr_sel, wd_sel} !== mon_exp) begin
                    errors++;
                    $display("FAIL mem_write got addr=%h data=%h expected addr=%h data=%h",
                             addr_sel, wd_sel, mon_exp[39:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last, input bit push, input logic [7:0] eaddr,
                        input logic [31:0] edata);
        int n;
        @(negedge clk);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
        n = 0;
        while (rdy_sel !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rdy_sel !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout op=%0d in_ready=%b expected 1", op, rdy_sel);
        end else if (push) begin
            sb.push_back({eaddr, edata});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_sel !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_sel !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout done=%b expected 1", done_sel);
        end
    endtask

    task automatic pulse_start(input logic [7:0] base);
        @(negedge clk);
        base_addr = base;
        if (use2) start2 = 1'b1;
        else      start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rdy8, we8, busy8, done8, err8, ovf8, addr8, wd8, cnt8} !== 55'd0) begin
            errors++;
            $display("FAIL reset_outputs8 got %h expected 0",
                     {rdy8, we8, busy8, done8, err8, ovf8, addr8, wd8, cnt8});
        end
        checks++;
        if ({rdy2, we2, busy2, done2, err2, ovf2, addr2, wd2, cnt2} !== 43'd0) begin
            errors++;
            $display("FAIL reset_outputs2 got %h expected 0",
                     {rdy2, we2, busy2, done2, err2, ovf2, addr2, wd2, cnt2});
        end
        rst = 1'b0;
    endtask

    task automatic test_program_load();
        pulse_start(8'h10);
        send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 1'b0, 1'b1, 8'h10, 32'h00221820);
        send(OP_ADDI, 5'd0, 5'd8, 5'd0, 16'h0005, 26'd0, 1'b0, 1'b1, 8'h11, 32'h20080005);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy8, done8, cnt8} !== {1'b1, 1'b0, 9'd2}) begin
            errors++;
            $display("FAIL load_midsession busy/done/count=%b/%b/%0d expected 1/0/2", busy8, done8, cnt8);
        end
        // start while loading must not re-base the pointer
        pulse_start(8'h40);
        send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 1'b1, 1'b1, 8'h12, 32'h00221820);
        wait_done();
        checks++;
        if (cnt8 !== 9'd3) begin
            errors++;
            $display("FAIL load_count got %0d expected 3", cnt8);
        end
    endtask

    task automatic test_mem_ops();
        bit saw_ready;
        pulse_start(8'h20);
        checks++;
        if ({busy8, done8, cnt8} !== {1'b1, 1'b0, 9'd0}) begin
            errors++;
            $display("FAIL restart_from_done busy/done/count=%b/%b/%0d expected 1/0/0", busy8, done8, cnt8);
        end
        send(OP_LW, 5'd8, 5'd9, 5'd0, 16'h0004, 26'd0, 1'b0, 1'b1, 8'h20, 32'h8D090004);
        send(OP_SW, 5'd8, 5'd9, 5'd0, 16'h0008, 26'd0, 1'b0, 1'b1, 8'h21, 32'hAD090008);
        send(OP_JAL, 5'd7, 5'd5, 5'd31, 16'hFFFF, 26'h0000010, 1'b1, 1'b1, 8'h22, 32'h0C000010);
        wait_done();
        checks++;
        if ({done8, busy8, err8, ovf8, cnt8} !== {1'b1, 1'b0, 1'b0, 1'b0, 9'd3}) begin
            errors++;
            $display("FAIL memops_status done/busy/err/ovf/count=%b/%b/%b/%b/%0d expected 1/0/0/0/3",
                     done8, busy8, err8, ovf8, cnt8);
        end
        saw_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rdy8 !== 1'b0) saw_ready = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (saw_ready || cnt8 !== 9'd3) begin
            errors++;
            $display("FAIL done_ignores_valid ready_seen=%b count=%0d expected 0 and 3", saw_ready, cnt8);
        end
    endtask

    task automatic test_illegal();
        pulse_start(8'h30);
        send(OP_ANDI, 5'd2, 5'd3, 5'd0, 16'h00FF, 26'd0, 1'b0, 1'b1, 8'h30, 32'h304300FF);
        send(4'd12, 5'd2, 5'd3, 5'd0, 16'h00FF, 26'd0, 1'b0, 1'b0, 8'h00, 32'h0);
        send(OP_ANDI, 5'd2, 5'd3, 5'd0, 16'h00FF, 26'd0, 1'b1, 1'b1, 8'h31, 32'h304300FF);
        wait_done();
        checks++;
        if ({err8, cnt8} !== {1'b1, 9'd2}) begin
            errors++;
            $display("FAIL illegal_status err/count=%b/%0d expected 1/2", err8, cnt8);
        end
        pulse_start(8'h38);
        checks++;
        if (err8 !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared_by_start got %b expected 0", err8);
        end
        send(4'd15, 5'd0, 5'd0, 5'd0, 16'h0000, 26'd0, 1'b1, 1'b0, 8'h00, 32'h0);
        wait_done();
        checks++;
        if ({err8, cnt8} !== {1'b1, 9'd0}) begin
            errors++;
            $display("FAIL illegal_last err/count=%b/%0d expected 1/0", err8, cnt8);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  ops [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        logic [5:0]  fns [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [4:0]  rs, rt, rd;
        pulse_start(8'h50);
        for (int i = 0; i < 4; i++) begin
            rs = 5'($urandom_range(0, 31));
            rt = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
            send(ops[i], rs, rt, rd, 16'($urandom), 26'($urandom), (i == 3), 1'b1,
                 8'h50 + 8'(i), {6'b000000, rs, rt, rd, 5'b00000, fns[i]});
        end
        wait_done();
        checks++;
        if (cnt8 !== 9'd4) begin
            errors++;
            $display("FAIL rtype_count got %0d expected 4", cnt8);
        end
    endtask

    task automatic test_handshake();
        int k;
        logic exp_rdy;
        pulse_start(8'h60);
        in_op = OP_ADD; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_last = 1'b0;
        in_valid = 1'b1;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            exp_rdy = (i % 2 == 0) ? 1'b1 : 1'b0;
            checks++;
            if (rdy8 !== exp_rdy) begin
                errors++;
                $display("FAIL handshake_ready cycle %0d got %b expected %b", i, rdy8, exp_rdy);
            end
            if (rdy8 === 1'b1) begin
                sb.push_back({8'h60 + 8'(k), 32'h00221820});
                k++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt8 !== 9'd4 || sb.size() != 0) begin
            errors++;
            $display("FAIL handshake_writes count=%0d pending=%0d expected 4 and 0", cnt8, sb.size());
        end
    endtask

    task automatic test_reset_in_write();
        do_reset();
        pulse_start(8'h70);
        send(OP_ADD, 5'd4, 5'd5, 5'd6, 16'h0000, 26'd0, 1'b0, 1'b0, 8'h00, 32'h0);
        rst = 1'b1;
        start8 = 1'b1;
        @(negedge clk);
        checks++;
        if (we8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_write mem_we got %b expected 0", we8);
        end
        @(negedge clk);
        checks++;
        if ({rdy8, we8, busy8, done8, err8, ovf8, addr8, wd8, cnt8} !== 55'd0) begin
            errors++;
            $display("FAIL reset_in_write_outputs got %h expected 0",
                     {rdy8, we8, busy8, done8, err8, ovf8, addr8, wd8, cnt8});
        end
        rst = 1'b0;
        start8 = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy8, rdy8, done8} !== 3'b000) begin
            errors++;
            $display("FAIL start_during_reset busy/ready/done=%b%b%b expected 000", busy8, rdy8, done8);
        end
    endtask

    task automatic test_wrap();
        bit saw_ready;
        logic [7:0] exp_addr [4] = '{8'd2, 8'd3, 8'd0, 8'd1};
        use2 = 1'b1;
        do_reset();
        pulse_start(8'h02);
        for (int i = 0; i < 4; i++) begin
            send(OP_ADDI, 5'd0, 5'd8, 5'd0, 16'(i + 1), 26'd0, 1'b0, 1'b1, exp_addr[i],
                 32'h20080000 | 32'(i + 1));
        end
        wait_done();
        checks++;
        if ({ovf2, done2, busy2, cnt2} !== {1'b1, 1'b1, 1'b0, 3'd4}) begin
            errors++;
            $display("FAIL wrap_status ovf/done/busy/count=%b/%b/%b/%0d expected 1/1/0/4",
                     ovf2, done2, busy2, cnt2);
        end
        saw_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rdy2 !== 1'b0) saw_ready = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (saw_ready) begin
            errors++;
            $display("FAIL wrap_fifth_accepted in_ready seen=%b expected 0", saw_ready);
        end
        use2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_program_load();
        test_mem_ops();
        test_illegal();
        test_rtype();
        test_handshake();
        test_reset_in_write();
        test_wrap();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes pending=%0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
